// File: rtl/fpu_chk_pkg.sv
// -----------------------------------------------------------------------------
// fpu_chk_pkg
// Shared definitions for the FPU result checker: checker FSM state encoding,
// default FPU pipeline latency, delay-line entry width and a single-precision
// NaN detector.
// -----------------------------------------------------------------------------
package fpu_chk_pkg;

   // Default number of cycles from operand drive to a valid FPU result.
   localparam int LAT_DEF = 2;

   // Delay-line entry: {valid, expected result[31:0], operand ex1[31:0]}.
   localparam int DLY_W = 65;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // IEEE-754 single precision NaN: all-ones exponent, non-zero fraction.
   function automatic logic is_nan(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
   endfunction

endpackage : fpu_chk_pkg

// File: rtl/fpu_chk_dly.sv
// -----------------------------------------------------------------------------
// fpu_chk_dly
// DEPTH-stage shift register that realigns each checker entry with the FPU
// result it belongs to. Bit W-1 of every entry is its valid flag.
//
// Ports
//   ACLK      in   clock, rising edge
//   RST       in   asynchronous active-high reset (clears valid flags only)
//   din       in   [W-1:0] entry pushed every cycle
//   dout      out  [W-1:0] entry pushed DEPTH edges ago
//   any_valid out  at least one stage holds a valid entry
// -----------------------------------------------------------------------------
module fpu_chk_dly
   import fpu_chk_pkg::*;
#(
   parameter int W     = DLY_W,
   parameter int DEPTH = LAT_DEF
) (
   input  logic         ACLK,
   input  logic         RST,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         any_valid
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [W-2:0]     data_q [DEPTH];
   logic [W-2:0]     data_d [DEPTH];

   // NOTE: every signal written here gets a value before any branch or loop,
   // so no path can leave it unassigned and infer a latch.
   always_comb begin
      valid_d[0] = din[W-1];
      data_d[0]  = din[W-2:0];
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1];
         data_d[i]  = data_q[i-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // the pre-edge value of its source, independent of statement order.
   always_ff @(posedge ACLK or posedge RST) begin
      if (RST) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // NOTE: the payload is deliberately not reset; it is only ever observed
   // behind a valid flag, and leaving it reset-free keeps it plain storage.
   always_ff @(posedge ACLK) begin
      data_q <= data_d;
   end

   assign dout      = {valid_q[DEPTH-1], data_q[DEPTH-1]};
   assign any_valid = |valid_q;

endmodule : fpu_chk_dly

// File: rtl/fpu_chk.sv
// -----------------------------------------------------------------------------
// fpu_chk
// Streams FMA test vectors into an FPU pipeline and checks each FPU result
// against the expected value LAT edges after the vector was accepted.
// Counts mismatches (saturating) and captures the first failing case.
//
// Build option: define FPU_CHK_NAN_EQ_EN to treat any two NaNs as equal
// regardless of sign and payload; otherwise all 32 bits compare exactly.
//
// Ports
//   ACLK, RST              clock (rising edge), async active-high reset
//   start                  pulse: begin a run (honoured in IDLE / DONE only)
//   vec_valid, vec_ready   vector handshake, accepted when both high
//   vec_last               accepted vector ends the run
//   vec_ex1..3, vec_exp    FMA operands and expected result
//   ex1..3                 operands held towards the FPU
//   fpu_exd                FPU result
//   busy, done             run in progress / run complete
//   err_cnt                saturating mismatch count
//   err_ex1/exd/exp        ex1, actual, expected of the first mismatch
// -----------------------------------------------------------------------------
module fpu_chk
   import fpu_chk_pkg::*;
#(
   parameter int LAT = LAT_DEF
) (
   input  logic        ACLK,
   input  logic        RST,
   input  logic        start,
   input  logic        vec_valid,
   output logic        vec_ready,
   input  logic        vec_last,
   input  logic [31:0] vec_ex1,
   input  logic [31:0] vec_ex2,
   input  logic [31:0] vec_ex3,
   input  logic [31:0] vec_exp,
   output logic [31:0] ex1,
   output logic [31:0] ex2,
   output logic [31:0] ex3,
   input  logic [31:0] fpu_exd,
   output logic        busy,
   output logic        done,
   output logic [15:0] err_cnt,
   output logic [31:0] err_ex1,
   output logic [31:0] err_exd,
   output logic [31:0] err_exp
);

   state_e      state_q, state_d;
   logic [31:0] ex1_q, ex1_d, ex2_q, ex2_d, ex3_q, ex3_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [31:0] err_ex1_q, err_ex1_d, err_exd_q, err_exd_d, err_exp_q, err_exp_d;

   logic             accept;
   logic [DLY_W-1:0] dly_in, dly_out;
   logic             dly_any_valid;
   logic             out_vld;
   logic [31:0]      out_exp, out_ex1;
   logic             res_match;

   assign accept = (state_q == ST_RUN) && vec_valid;
   // Bubbles are pushed with valid=0 so they never reach the comparator.
   assign dly_in = {accept, vec_exp, vec_ex1};

   fpu_chk_dly #(
      .W     (DLY_W),
      .DEPTH (LAT)
   ) u_dly (
      .ACLK      (ACLK),
      .RST       (RST),
      .din       (dly_in),
      .dout      (dly_out),
      .any_valid (dly_any_valid)
   );

   assign out_vld = dly_out[64];
   assign out_exp = dly_out[63:32];
   assign out_ex1 = dly_out[31:0];

   always_comb begin
      res_match = (fpu_exd == out_exp);
`ifdef FPU_CHK_NAN_EQ_EN
      if (is_nan(fpu_exd) && is_nan(out_exp)) begin
         res_match = 1'b1;
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      ex1_d     = ex1_q;
      ex2_d     = ex2_q;
      ex3_d     = ex3_q;
      err_cnt_d = err_cnt_q;
      err_ex1_d = err_ex1_q;
      err_exd_d = err_exd_q;
      err_exp_d = err_exp_q;

      if (accept) begin
         ex1_d = vec_ex1;
         ex2_d = vec_ex2;
         ex3_d = vec_ex3;
      end

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_RUN;
               err_cnt_d = '0;
               err_ex1_d = '0;
               err_exd_d = '0;
               err_exp_d = '0;
            end
         end
         ST_RUN: begin
            if (accept && vec_last) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Once the last valid entry has been compared the line is empty.
            if (!dly_any_valid) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_q == ST_RUN || state_q == ST_DRAIN) && out_vld && !res_match) begin
         if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
         if (err_cnt_q == 16'd0) begin
            err_ex1_d = out_ex1;
            err_exd_d = fpu_exd;
            err_exp_d = out_exp;
         end
      end
   end

   always_ff @(posedge ACLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         ex1_q     <= '0;
         ex2_q     <= '0;
         ex3_q     <= '0;
         err_cnt_q <= '0;
         err_ex1_q <= '0;
         err_exd_q <= '0;
         err_exp_q <= '0;
      end else begin
         state_q   <= state_d;
         ex1_q     <= ex1_d;
         ex2_q     <= ex2_d;
         ex3_q     <= ex3_d;
         err_cnt_q <= err_cnt_d;
         err_ex1_q <= err_ex1_d;
         err_exd_q <= err_exd_d;
         err_exp_q <= err_exp_d;
      end
   end

   assign vec_ready = (state_q == ST_RUN);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign ex1       = ex1_q;
   assign ex2       = ex2_q;
   assign ex3       = ex3_q;
   assign err_cnt   = err_cnt_q;
   assign err_ex1   = err_ex1_q;
   assign err_exd   = err_exd_q;
   assign err_exp   = err_exp_q;

endmodule : fpu_chk

// File: tb/tb_fpu_chk.sv
// -----------------------------------------------------------------------------
// tb_fpu_chk
// Self-checking bench for fpu_chk. A behavioural FPU stand-in returns a
// per-vector "actual" result LAT edges after acceptance and returns a junk
// word on bubble cycles, so any compare on a bubble shows up as an error.
// -----------------------------------------------------------------------------
module tb_fpu_chk;

   localparam int LAT = 2;

   logic        ACLK, RST, start;
   logic        vec_valid, vec_ready, vec_last;
   logic [31:0] vec_ex1, vec_ex2, vec_ex3, vec_exp, vec_act;
   logic [31:0] ex1, ex2, ex3, fpu_exd;
   logic        busy, done;
   logic [15:0] err_cnt;
   logic [31:0] err_ex1, err_exd, err_exp;

   int n_checks = 0;
   int n_fail   = 0;

   fpu_chk #(.LAT(LAT)) dut (
      .ACLK      (ACLK),
      .RST       (RST),
      .start     (start),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .vec_last  (vec_last),
      .vec_ex1   (vec_ex1),
      .vec_ex2   (vec_ex2),
      .vec_ex3   (vec_ex3),
      .vec_exp   (vec_exp),
      .ex1       (ex1),
      .ex2       (ex2),
      .ex3       (ex3),
      .fpu_exd   (fpu_exd),
      .busy      (busy),
      .done      (done),
      .err_cnt   (err_cnt),
      .err_ex1   (err_ex1),
      .err_exd   (err_exd),
      .err_exp   (err_exp)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // FPU stand-in: LAT-stage pipe, result visible in the cycle before the
   // edge that lies LAT edges after acceptance.
   logic [31:0] fpu_pipe [LAT];
   always @(posedge ACLK) begin
      fpu_pipe[0] <= (vec_valid && vec_ready) ? vec_act : 32'hDEADBEEF;
      for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
   end
   assign fpu_exd = fpu_pipe[LAT-1];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (actual timeout, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %08h required %08h", name, act, req);
      end
   endtask

   // Called at a negedge; start is high across exactly one rising edge.
   task automatic do_start();
      start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the acceptance edge.
   task automatic send_vec(input logic [31:0] a, b, c, e, act, input logic last);
      int t;
      vec_valid = 1'b1;
      vec_ex1 = a; vec_ex2 = b; vec_ex3 = c; vec_exp = e; vec_act = act;
      vec_last = last;
      t = 0;
      while (!vec_ready && t < 20) begin
         @(negedge ACLK);
         t++;
      end
      check("vec_ready before accept", 32'(vec_ready), 32'd1);
      @(posedge ACLK);
      @(negedge ACLK);
      vec_valid = 1'b0;
      vec_last  = 1'b0;
   endtask

   // Counts negedges from the post-acceptance negedge until done is seen.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 50) begin
         @(negedge ACLK);
         lat++;
      end
      check("done reached", 32'(done), 32'd1);
   endtask

   typedef struct {
      logic [31:0] ex1, ex2, ex3, exp, act;
      logic [15:0] cnt;
      logic [31:0] e_ex1, e_exd, e_exp;
   } vec_t;

   vec_t tbl [5];
   int   lat_seen;

   initial begin
      // Single-vector runs: {ex1, ex2, ex3, exp, fpu actual, err_cnt, err_ex1, err_exd, err_exp}
      tbl[0] = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h40000000, 32'h40000000,
                 16'd0, 32'h0, 32'h0, 32'h0};
      tbl[1] = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h40000001, 32'h40000000,
                 16'd1, 32'h3f800000, 32'h40000000, 32'h40000001};
`ifdef FPU_CHK_NAN_EQ_EN
      tbl[2] = '{32'h7f800001, 32'h40400000, 32'h40800000, 32'hffc00001, 32'h7fc00000,
                 16'd0, 32'h0, 32'h0, 32'h0};
`else
      tbl[2] = '{32'h7f800001, 32'h40400000, 32'h40800000, 32'hffc00001, 32'h7fc00000,
                 16'd1, 32'h7f800001, 32'h7fc00000, 32'hffc00001};
`endif
      // +0 vs -0 and Inf vs NaN differ in every build.
      tbl[3] = '{32'h00000000, 32'hbf800000, 32'h00000000, 32'h80000000, 32'h00000000,
                 16'd1, 32'h00000000, 32'h00000000, 32'h80000000};
      tbl[4] = '{32'h7f800000, 32'h3f800000, 32'h00000000, 32'h7f800001, 32'h7f800000,
                 16'd1, 32'h7f800000, 32'h7f800000, 32'h7f800001};

      RST = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
      vec_ex1 = '0; vec_ex2 = '0; vec_ex3 = '0; vec_exp = '0; vec_act = '0;
      repeat (3) @(negedge ACLK);

      check("reset vec_ready", 32'(vec_ready), 32'd0);
      check("reset busy",      32'(busy),      32'd0);
      check("reset done",      32'(done),      32'd0);
      check("reset err_cnt",   32'(err_cnt),   32'd0);
      check("reset ex1",       ex1,            32'd0);
      check("reset err_exd",   err_exd,        32'd0);
      RST = 1'b0;
      @(negedge ACLK);
      check("idle vec_ready", 32'(vec_ready), 32'd0);

      // ---------------- table-driven single-vector runs ----------------
      for (int i = 0; i < 5; i++) begin
         do_start();
         check($sformatf("r%0d busy after start", i),    32'(busy),    32'd1);
         check($sformatf("r%0d err_cnt after start", i), 32'(err_cnt), 32'd0);
         check($sformatf("r%0d err_ex1 after start", i), err_ex1,      32'd0);
         send_vec(tbl[i].ex1, tbl[i].ex2, tbl[i].ex3, tbl[i].exp, tbl[i].act, 1'b1);
         check($sformatf("r%0d ex1", i), ex1, tbl[i].ex1);
         check($sformatf("r%0d ex2", i), ex2, tbl[i].ex2);
         check($sformatf("r%0d ex3", i), ex3, tbl[i].ex3);
         check($sformatf("r%0d drain vec_ready", i), 32'(vec_ready), 32'd0);
         check($sformatf("r%0d drain busy", i),      32'(busy),      32'd1);
         wait_done(lat_seen);
         // done first seen LAT+1 edges after the acceptance edge, i.e. in the
         // (LAT+2)-th cycle counting the acceptance cycle as cycle 0.
         check($sformatf("r%0d done latency", i), 32'(lat_seen), 32'(LAT + 1));
         check($sformatf("r%0d busy in done", i), 32'(busy), 32'd0);
         check($sformatf("r%0d err_cnt", i), 32'(err_cnt), 32'(tbl[i].cnt));
         check($sformatf("r%0d err_ex1", i), err_ex1, tbl[i].e_ex1);
         check($sformatf("r%0d err_exd", i), err_exd, tbl[i].e_exd);
         check($sformatf("r%0d err_exp", i), err_exp, tbl[i].e_exp);
      end

      // ---------------- 4 vectors with a 2-cycle gap -------------------
      do_start();
      send_vec(32'h11111111, 32'h1, 32'h2, 32'h0000AAAA, 32'h0000AAAB, 1'b0);
      send_vec(32'h22222222, 32'h3, 32'h4, 32'h3f800000, 32'h3f800000, 1'b0);
      @(negedge ACLK);
      check("gap ex1 hold",   ex1,             32'h22222222);
      check("gap vec_ready",  32'(vec_ready),  32'd1);
      @(negedge ACLK);
      send_vec(32'h33333333, 32'h5, 32'h6, 32'hc0000000, 32'h40000000, 1'b0);
      send_vec(32'h44444444, 32'h7, 32'h8, 32'h00000000, 32'h00000000, 1'b1);
      wait_done(lat_seen);
      check("gap err_cnt", 32'(err_cnt), 32'd2);
      check("gap err_ex1", err_ex1,      32'h11111111);
      check("gap err_exd", err_exd,      32'h0000AAAB);
      check("gap err_exp", err_exp,      32'h0000AAAA);
      check("gap ex1 last", ex1,         32'h44444444);
      check("gap ex3 last", ex3,         32'h8);

      // ---------------- start in RUN ignored, start in DONE clears -----
      do_start();
      send_vec(32'h55555555, 32'h1, 32'h1, 32'h12345678, 32'h87654321, 1'b0);
      repeat (LAT + 1) @(negedge ACLK);
      check("run err_cnt", 32'(err_cnt), 32'd1);
      do_start();
      check("run start busy",      32'(busy),      32'd1);
      check("run start vec_ready", 32'(vec_ready), 32'd1);
      check("run start err_cnt",   32'(err_cnt),   32'd1);
      send_vec(32'h66666666, 32'h1, 32'h1, 32'h3f800000, 32'h3f800000, 1'b1);
      wait_done(lat_seen);
      check("run final err_cnt", 32'(err_cnt), 32'd1);
      check("run final err_ex1", err_ex1,      32'h55555555);
      do_start();
      check("restart done",      32'(done),      32'd0);
      check("restart vec_ready", 32'(vec_ready), 32'd1);
      check("restart err_cnt",   32'(err_cnt),   32'd0);
      check("restart err_exd",   err_exd,        32'd0);
      send_vec(32'h77777777, 32'h1, 32'h1, 32'h40000000, 32'h40000000, 1'b1);
      wait_done(lat_seen);
      check("restart final err_cnt", 32'(err_cnt), 32'd0);

      // ---------------- reset during DRAIN with pending mismatch ------
      do_start();
      send_vec(32'h88888888, 32'h9, 32'hA, 32'h40000001, 32'h40000000, 1'b1);
      check("pre-reset busy",    32'(busy),    32'd1);
      check("pre-reset err_cnt", 32'(err_cnt), 32'd0);
      RST = 1'b1;
      #1;
      check("rst busy",      32'(busy),      32'd0);
      check("rst done",      32'(done),      32'd0);
      check("rst vec_ready", 32'(vec_ready), 32'd0);
      check("rst ex1",       ex1,            32'd0);
      check("rst ex2",       ex2,            32'd0);
      check("rst ex3",       ex3,            32'd0);
      check("rst err_ex1",   err_ex1,        32'd0);
      @(negedge ACLK);
      @(negedge ACLK);
      RST = 1'b0;
      repeat (LAT + 3) @(negedge ACLK);
      check("post-rst err_cnt", 32'(err_cnt), 32'd0);
      check("post-rst err_exd", err_exd,      32'd0);
      check("post-rst busy",    32'(busy),    32'd0);
      check("post-rst done",    32'(done),    32'd0);
      do_start();
      check("post-rst start from idle", 32'(vec_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fpu_chk
